serial_rx_controller: RTL and testbench
=======================================

SERIAL_RX_CONTROLLER -- requirements
Module: serial_rx_controller

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit (even, >= 4).
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL have port RX_IN  input  1  serial line; idle high; frame = 1 start (low) + 8 data (MSB first) + 1 stop (high).
REQ-005 SHALL have port DATA_OUT  output  8  last accepted byte.
REQ-006 SHALL have port DATA_VALID  output  1  DATA_OUT holds an unconsumed byte.
REQ-007 SHALL have port DATA_READY  input  1  consumer accepts DATA_OUT when high with DATA_VALID.
REQ-008 SHALL have port BUSY  output  1  high in every state except IDLE.
REQ-009 SHALL have port FRAME_ERROR  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 SHALL have port OVERRUN  output  1  one-cycle pulse: completed byte dropped because DATA_VALID was still pending.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-012 IDLE: RX_IN sampled low -> START, cycle counter cleared to 0.
REQ-013 START: at counter = CLKS_PER_BIT/2-1, RX_IN low -> DATA with counter 0; RX_IN high -> IDLE (glitch reject, no flags).
REQ-014 DATA: at counter = CLKS_PER_BIT-1, SHALL assert internal shift enable for exactly one cycle with the current RX_IN as shift-in bit, increment bit count, clear counter.
REQ-015 Shift register SHALL shift toward MSB (new bit into bit 0), so the first data bit ends in DATA_OUT[7].
REQ-016 After the 8th shift SHALL enter STOP; bit count SHALL wrap to 0.
REQ-017 STOP: at counter = CLKS_PER_BIT-1, RX_IN high -> byte complete; RX_IN low -> FRAME_ERROR pulse next cycle, byte discarded, DATA_OUT/DATA_VALID unchanged; both cases -> IDLE.
REQ-018 Byte complete with DATA_VALID low, or DATA_VALID and DATA_READY both high that cycle: DATA_OUT loaded, DATA_VALID = 1 on the following cycle (latency 1 cycle after stop sample).
REQ-019 Byte complete with DATA_VALID high and DATA_READY low: DATA_OUT keeps old byte, DATA_VALID stays 1, OVERRUN pulses next cycle.
REQ-020 DATA_VALID and DATA_READY high, no completion: DATA_VALID = 0 next cycle; DATA_OUT held.
REQ-021 DATA_READY while DATA_VALID low SHALL have no effect.
REQ-022 Receiver SHALL accept a new start bit in IDLE regardless of DATA_VALID.
REQ-023 Counter width SHALL be $clog2(CLKS_PER_BIT); bit count 3 bits.

Reset
REQ-024 RESET high at a rising edge SHALL force IDLE, counters 0, shift register 0, DATA_OUT = 8'h00, DATA_VALID/BUSY/FRAME_ERROR/OVERRUN = 0, overriding all other inputs.
REQ-025 Reset mid-frame SHALL abandon the frame with no flags; next falling RX_IN after reset release starts a fresh frame.

Structure
REQ-026 Shared package rx_ctrl_pkg SHALL hold the state enum, DATA_BITS = 8, and the default CLKS_PER_BIT.
REQ-027 The 8-bit shift register SHALL be a sub-module rx_shift_reg (ports CLK, RESET, SHIFT_ENABLE, DATA_IN, q) driven solely by this controller.
REQ-028 Synthesizable RTL, single clock domain, no latches.

Verification (CLKS_PER_BIT = 4)
REQ-029 Frame 0xA5, DATA_READY low -> DATA_OUT = 8'hA5, DATA_VALID = 1 one cycle after the stop sample, held; no flags.
REQ-030 Two back-to-back frames 0x3C then 0xC3, DATA_READY low -> DATA_OUT stays 8'h3C, OVERRUN one-cycle pulse at the second completion.
REQ-031 RX_IN low for 1 cycle then high in IDLE -> return to IDLE, BUSY drops, no shifts, DATA_VALID unchanged.
REQ-032 Frame 0x81 with stop bit low -> FRAME_ERROR one-cycle pulse, DATA_VALID stays 0, DATA_OUT = 8'h00.
REQ-033 DATA_READY high in the stop-sample cycle while 0x11 pending, new frame 0x22 -> DATA_OUT = 8'h22, DATA_VALID stays 1, no OVERRUN.
REQ-034 RESET high during 4th data bit -> all outputs 0 next cycle; subsequent frame 0x5A received correctly.

Source files
------------

// File: rtl/rx_ctrl_pkg.sv
// Shared types and constants for the serial receive controller.
package rx_ctrl_pkg;

    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 16;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } rx_state_e;

endpackage

// File: rtl/rx_shift_reg.sv
// Serial-in shift register; new bits enter at bit 0 so the first bit received ends in the MSB.
module rx_shift_reg
    import rx_ctrl_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 SHIFT_ENABLE,
    input  logic                 DATA_IN,
    output logic [DATA_BITS-1:0] q
);

    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;

    always_comb begin
        shift_d = shift_q;
        if (SHIFT_ENABLE) begin
            shift_d = {shift_q[DATA_BITS-2:0], DATA_IN};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign q = shift_q;

endmodule

// File: rtl/serial_rx_controller.sv
// Start/8-data/stop serial receiver with a single-entry valid/ready output holding register.
module serial_rx_controller
    import rx_ctrl_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 RX_IN,
    output logic [DATA_BITS-1:0] DATA_OUT,
    output logic                 DATA_VALID,
    input  logic                 DATA_READY,
    output logic                 BUSY,
    output logic                 FRAME_ERROR,
    output logic                 OVERRUN
);

    localparam int unsigned CntW    = $clog2(CLKS_PER_BIT);
    localparam int unsigned BitCntW = $clog2(DATA_BITS);

    localparam logic [CntW-1:0]    HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0]    BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [BitCntW-1:0] LastBit  = BitCntW'(DATA_BITS - 1);

    rx_state_e            state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 fe_q, fe_d;
    logic                 ov_q, ov_d;

    logic                 shift_en;
    logic                 byte_done;
    logic                 stop_bad;
    logic [DATA_BITS-1:0] sr_q;

    rx_shift_reg u_shift_reg (
        .CLK          (CLK),
        .RESET        (RESET),
        .SHIFT_ENABLE (shift_en),
        .DATA_IN      (RX_IN),
        .q            (sr_q)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        shift_en  = 1'b0;
        byte_done = 1'b0;
        stop_bad  = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!RX_IN) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                // Mid-start-bit check rejects glitches shorter than half a bit.
                if (cnt_q == HalfLast) begin
                    cnt_d   = '0;
                    state_d = RX_IN ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d     = '0;
                    shift_en  = 1'b1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LastBit) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d     = '0;
                    state_d   = StIdle;
                    byte_done = RX_IN;
                    stop_bad  = !RX_IN;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        fe_d    = stop_bad;
        ov_d    = 1'b0;

        // A completing byte may replace the pending one only if it is consumed this cycle.
        if (byte_done) begin
            if (!valid_q || DATA_READY) begin
                data_d  = sr_q;
                valid_d = 1'b1;
            end else begin
                ov_d = 1'b1;
            end
        end else if (valid_q && DATA_READY) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            fe_q      <= fe_d;
            ov_q      <= ov_d;
        end
    end

    assign DATA_OUT    = data_q;
    assign DATA_VALID  = valid_q;
    assign BUSY        = (state_q != StIdle);
    assign FRAME_ERROR = fe_q;
    assign OVERRUN     = ov_q;

endmodule

// File: tb/tb_serial_rx_controller.sv
// Directed bench for serial_rx_controller at 4 clocks per bit, checked against a frame-schedule model.
module tb_serial_rx_controller;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       RX_IN;
    logic       DATA_READY;
    logic [7:0] DATA_OUT;
    logic       DATA_VALID;
    logic       BUSY;
    logic       FRAME_ERROR;
    logic       OVERRUN;

    serial_rx_controller #(
        .CLKS_PER_BIT (4)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .RX_IN       (RX_IN),
        .DATA_OUT    (DATA_OUT),
        .DATA_VALID  (DATA_VALID),
        .DATA_READY  (DATA_READY),
        .BUSY        (BUSY),
        .FRAME_ERROR (FRAME_ERROR),
        .OVERRUN     (OVERRUN)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Frame schedule: a frame whose start edge is driven after edge c0 completes at edge c0+39
    // and keeps the receiver busy for edges c0+1 .. c0+38.
    int         cyc        = 0;
    int         busy_start = 0;
    int         busy_end   = 0;
    int         pend_cycle = -1;
    logic [7:0] pend_byte  = 8'h00;
    logic       pend_ok    = 1'b1;

    logic [7:0] m_data  = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_fe    = 1'b0;
    logic       m_ov    = 1'b0;
    logic       m_busy  = 1'b0;

    always @(posedge CLK) begin
        int n;
        n = cyc + 1;
        cyc <= n;
        if (RESET) begin
            m_data  <= 8'h00;
            m_valid <= 1'b0;
            m_fe    <= 1'b0;
            m_ov    <= 1'b0;
            m_busy  <= 1'b0;
        end else begin
            m_fe   <= 1'b0;
            m_ov   <= 1'b0;
            m_busy <= (n >= busy_start) && (n < busy_end);
            if (n == pend_cycle) begin
                if (!pend_ok) begin
                    m_fe <= 1'b1;
                end else if (!m_valid || DATA_READY) begin
                    m_data  <= pend_byte;
                    m_valid <= 1'b1;
                end else begin
                    m_ov <= 1'b1;
                end
            end else if (m_valid && DATA_READY) begin
                m_valid <= 1'b0;
            end
        end
    end

    logic check_en = 1'b0;
    int   fe_cnt   = 0;
    int   ov_cnt   = 0;

    always @(negedge CLK) begin
        if (check_en) begin
            check("busy", 32'(BUSY), 32'(m_busy));
            check("data_valid", 32'(DATA_VALID), 32'(m_valid));
            check("data_out", 32'(DATA_OUT), 32'(m_data));
            check("frame_error", 32'(FRAME_ERROR), 32'(m_fe));
            check("overrun", 32'(OVERRUN), 32'(m_ov));
            fe_cnt += 32'(FRAME_ERROR);
            ov_cnt += 32'(OVERRUN);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic rdy_at_stop,
                              input int abort_bit);
        int c0;
        c0         = cyc;
        pend_byte  = b;
        pend_ok    = stop_bit;
        pend_cycle = c0 + 39;
        busy_start = c0 + 1;
        busy_end   = c0 + 39;
        RX_IN      = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 8; i++) begin
            RX_IN = b[7-i];
            for (int j = 0; j < 4; j++) begin
                tick();
                if (i == abort_bit && j == 1) begin
                    RESET      = 1'b1;
                    RX_IN      = 1'b1;
                    pend_cycle = -1;
                    busy_end   = 0;
                    tick();
                    RESET = 1'b0;
                    check("abort_data", 32'(DATA_OUT), 32'h0);
                    check("abort_valid", 32'(DATA_VALID), 32'h0);
                    check("abort_busy", 32'(BUSY), 32'h0);
                    return;
                end
            end
        end
        RX_IN = stop_bit;
        for (int j = 0; j < 4; j++) begin
            tick();
            if (rdy_at_stop && j == 1) DATA_READY = 1'b1;
            if (j == 2) begin
                if (rdy_at_stop) DATA_READY = 1'b0;
                RX_IN = 1'b1;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fe0;
        int ov0;
        RESET      = 1'b1;
        RX_IN      = 1'b1;
        DATA_READY = 1'b0;
        tick();
        check_en = 1'b1;
        tick();
        RESET = 1'b0;
        tick();
        check("reset_data", 32'(DATA_OUT), 32'h00);
        check("reset_valid", 32'(DATA_VALID), 32'h0);
        check("reset_busy", 32'(BUSY), 32'h0);

        // Single frame, consumer stalled.
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        check("a5_data", 32'(DATA_OUT), 32'hA5);
        check("a5_valid", 32'(DATA_VALID), 32'h1);
        check("a5_no_fe", 32'(fe_cnt - fe0), 32'h0);
        check("a5_no_ov", 32'(ov_cnt - ov0), 32'h0);
        repeat (5) tick();
        check("a5_held", 32'({DATA_VALID, DATA_OUT}), 32'h1A5);

        // Consume, then READY without VALID must be harmless.
        DATA_READY = 1'b1;
        tick();
        check("consume_valid", 32'(DATA_VALID), 32'h0);
        check("consume_data", 32'(DATA_OUT), 32'hA5);
        repeat (3) tick();
        DATA_READY = 1'b0;
        tick();
        check("idle_ready_valid", 32'(DATA_VALID), 32'h0);

        // Back-to-back frames with the first never consumed.
        ov0 = ov_cnt;
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        send_frame(8'hC3, 1'b1, 1'b0, -1);
        check("overrun_data", 32'(DATA_OUT), 32'h3C);
        check("overrun_valid", 32'(DATA_VALID), 32'h1);
        check("overrun_pulses", 32'(ov_cnt - ov0), 32'h1);

        // One-cycle low glitch on an idle line.
        busy_start = cyc + 1;
        busy_end   = cyc + 3;
        RX_IN      = 1'b0;
        tick();
        RX_IN = 1'b1;
        repeat (6) tick();
        check("glitch_busy", 32'(BUSY), 32'h0);
        check("glitch_data", 32'({DATA_VALID, DATA_OUT}), 32'h13C);

        // Bad stop bit from a clean reset.
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        tick();
        fe0 = fe_cnt;
        send_frame(8'h81, 1'b0, 1'b0, -1);
        check("fe_pulses", 32'(fe_cnt - fe0), 32'h1);
        check("fe_valid", 32'(DATA_VALID), 32'h0);
        check("fe_data", 32'(DATA_OUT), 32'h00);

        // Pending byte consumed in the very cycle the next one completes.
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1, 1'b0, -1);
        check("p11_data", 32'(DATA_OUT), 32'h11);
        send_frame(8'h22, 1'b1, 1'b1, -1);
        check("p22_data", 32'(DATA_OUT), 32'h22);
        check("p22_valid", 32'(DATA_VALID), 32'h1);
        check("p22_no_ov", 32'(ov_cnt - ov0), 32'h0);

        // Reset during the 4th data bit, then a clean frame.
        send_frame(8'h77, 1'b1, 1'b0, 3);
        repeat (3) tick();
        send_frame(8'h5A, 1'b1, 1'b0, -1);
        check("post_reset_data", 32'(DATA_OUT), 32'h5A);
        check("post_reset_valid", 32'(DATA_VALID), 32'h1);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
